// File: rtl/cdiv_rr_arbiter.sv
// Round-robin front end that shares one complex_div among NUM_REQ requesters.
// A tag FIFO records who issued each in-flight op so results go back to the owner.
module cdiv_rr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0][3:0][63:0]  req_operands_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [1:0][63:0]               resp_result_o,
  output logic [4:0]                     resp_status_o,
  output logic [NUM_REQ-1:0]             resp_valid_o,
  input  logic [NUM_REQ-1:0]             resp_ready_i,
  output logic [3:0][63:0]               div_operands_o,
  output logic                           div_in_valid_o,
  input  logic                           div_in_ready_i,
  input  logic [1:0][63:0]               div_result_i,
  input  logic [4:0]                     div_status_i,
  input  logic                           div_out_valid_i,
  output logic                           div_out_ready_o,
  output logic                           div_flush_o,
  output logic                           busy_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {ST_ARB, ST_HOLD} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   lock_q, lock_d;
  logic [IDX_W-1:0]   fifo_q [MAX_OUTST];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   grant_idx;
  logic               push, pop;
  logic [IDX_W-1:0]   head;
  logic               has_entry;

  assign head      = fifo_q[rd_ptr_q];
  assign has_entry = (count_q != '0);

  // First valid requester at or after rr_ptr, wrapping around
  always_comb begin
    logic [IDX_W:0] sum;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      if (!found && req_valid_i[sum[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[IDX_W-1:0];
      end
    end
  end

  // Issue FSM: grant, hold a stalled grant, push the owner tag on acceptance
  always_comb begin
    state_d        = state_q;
    lock_d         = lock_q;
    rr_ptr_d       = rr_ptr_q;
    grant_idx      = lock_q;
    push           = 1'b0;
    div_in_valid_o = 1'b0;
    div_operands_o = '0;
    req_ready_o    = '0;
    if (!rst_i && !flush_i) begin
      unique case (state_q)
        ST_ARB: begin
          if (found && (count_q < CNT_W'(MAX_OUTST))) begin
            grant_idx      = pick;
            div_in_valid_o = 1'b1;
            if (div_in_ready_i) begin
              push = 1'b1;
            end else begin
              lock_d  = pick;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          grant_idx      = lock_q;
          div_in_valid_o = 1'b1;
          if (div_in_ready_i) begin
            push    = 1'b1;
            state_d = ST_ARB;
          end
        end
        default: state_d = ST_ARB;
      endcase
      if (div_in_valid_o) div_operands_o = req_operands_i[grant_idx];
      if (push) begin
        req_ready_o[grant_idx] = 1'b1;
        rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

  // Return path: route divider output to the tag at the FIFO head
  always_comb begin
    resp_valid_o    = '0;
    div_out_ready_o = 1'b0;
    pop             = 1'b0;
    if (!rst_i && !flush_i) begin
      if (has_entry) begin
        resp_valid_o[head] = div_out_valid_i;
        div_out_ready_o    = resp_ready_i[head];
      end else begin
        div_out_ready_o = 1'b1;
      end
      pop = div_out_valid_i & div_out_ready_o & has_entry;
    end
  end

  assign resp_result_o = div_result_i;
  assign resp_status_o = div_status_i;
  assign div_flush_o   = flush_i;
  assign busy_o        = !rst_i & ((state_q == ST_HOLD) | has_entry | div_in_valid_o);

  // State, pointers, tag FIFO and occupancy count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_ARB;
      rr_ptr_q <= '0;
      lock_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
    end else if (flush_i) begin
      state_q  <= ST_ARB;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      rr_ptr_q <= rr_ptr_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= grant_idx;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

`ifndef SYNTHESIS
  // A result with nothing outstanding means the divider broke ordering
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      assert (!(div_out_valid_i && !has_entry))
        else $error("cdiv_rr_arbiter: divider result with no op outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_cdiv_rr_arbiter.sv
// Directed bench for cdiv_rr_arbiter: vector table plus hand sequences.
module tb_cdiv_rr_arbiter;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  flush_i;
  logic [3:0][3:0][63:0] req_operands_i;
  logic [3:0]            req_valid_i;
  logic [3:0]            req_ready_o;
  logic [1:0][63:0]      resp_result_o;
  logic [4:0]            resp_status_o;
  logic [3:0]            resp_valid_o;
  logic [3:0]            resp_ready_i;
  logic [3:0][63:0]      div_operands_o;
  logic                  div_in_valid_o;
  logic                  div_in_ready_i;
  logic [1:0][63:0]      div_result_i;
  logic [4:0]            div_status_i;
  logic                  div_out_valid_i;
  logic                  div_out_ready_o;
  logic                  div_flush_o;
  logic                  busy_o;

  cdiv_rr_arbiter #(.NUM_REQ(4), .MAX_OUTST(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_operands_i(req_operands_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .resp_result_o(resp_result_o), .resp_status_o(resp_status_o), .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i), .div_operands_o(div_operands_o), .div_in_valid_o(div_in_valid_o),
    .div_in_ready_i(div_in_ready_i), .div_result_i(div_result_i), .div_status_i(div_status_i),
    .div_out_valid_i(div_out_valid_i), .div_out_ready_o(div_out_ready_o),
    .div_flush_o(div_flush_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [63:0] F5 = 64'h4014000000000000;
  localparam logic [63:0] F7 = 64'h401C000000000000;
  localparam logic [63:0] F9 = 64'h4022000000000000;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       in_ready;
    logic [3:0] exp_ready;
    logic       exp_in_valid;
    logic [1:0] exp_g;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(logic r, logic [3:0] v, logic ir, logic [3:0] er,
                              logic eiv, logic [1:0] eg, logic eb);
    vec_t t;
    t.rst = r; t.valid = v; t.in_ready = ir; t.exp_ready = er;
    t.exp_in_valid = eiv; t.exp_g = eg; t.exp_busy = eb;
    return t;
  endfunction

  function automatic logic [63:0] opval(int r, int k);
    return {48'h0, 8'(r), 8'(k)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    rst_i = 1'b0; flush_i = 1'b0; req_valid_i = '0; div_in_ready_i = 1'b1;
    resp_ready_i = 4'hF; div_out_valid_i = 1'b0; div_result_i = '0; div_status_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic chk_grant(input string name, input logic [3:0] er, input int g);
    chk({name, ".ready"}, 64'(req_ready_o), 64'(er));
    chk({name, ".in_valid"}, 64'(div_in_valid_o), 64'(1));
    chk({name, ".op0"}, div_operands_o[0], opval(g, 0));
    chk({name, ".op3"}, div_operands_o[3], opval(g, 3));
  endtask

  initial begin
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) req_operands_i[r][k] = opval(r, k);
    idle_inputs();
    rst_i = 1'b1;
    cyc();

    // rst valid ir  exp_ready in_v g  busy
    tbl[0]  = mk(1, 4'hF, 1, 4'h0, 0, 0, 0);
    tbl[1]  = mk(0, 4'hF, 1, 4'h1, 1, 0, 1);
    tbl[2]  = mk(0, 4'hF, 1, 4'h2, 1, 1, 1);
    tbl[3]  = mk(0, 4'hF, 1, 4'h4, 1, 2, 1);
    tbl[4]  = mk(0, 4'hF, 1, 4'h8, 1, 3, 1);
    tbl[5]  = mk(0, 4'hF, 1, 4'h1, 1, 0, 1);
    tbl[6]  = mk(1, 4'h0, 1, 4'h0, 0, 0, 0);
    tbl[7]  = mk(0, 4'h2, 0, 4'h0, 1, 1, 1);
    tbl[8]  = mk(0, 4'h3, 0, 4'h0, 1, 1, 1);
    tbl[9]  = mk(0, 4'h3, 0, 4'h0, 1, 1, 1);
    tbl[10] = mk(0, 4'h3, 1, 4'h2, 1, 1, 1);
    tbl[11] = mk(0, 4'h1, 1, 4'h1, 1, 0, 1);
    tbl[12] = mk(0, 4'h3, 1, 4'h2, 1, 1, 1);
    tbl[13] = mk(0, 4'h0, 1, 4'h0, 0, 0, 1);
    tbl[14] = mk(0, 4'h9, 1, 4'h8, 1, 3, 1);
    tbl[15] = mk(0, 4'h9, 1, 4'h1, 1, 0, 1);
    tbl[16] = mk(0, 4'h5, 0, 4'h0, 1, 2, 1);
    tbl[17] = mk(0, 4'h5, 1, 4'h4, 1, 2, 1);
    tbl[18] = mk(1, 4'h5, 1, 4'h0, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      rst_i = tbl[i].rst; req_valid_i = tbl[i].valid; div_in_ready_i = tbl[i].in_ready;
      settle();
      chk({nm, ".ready"}, 64'(req_ready_o), 64'(tbl[i].exp_ready));
      chk({nm, ".in_valid"}, 64'(div_in_valid_o), 64'(tbl[i].exp_in_valid));
      chk({nm, ".busy"}, 64'(busy_o), 64'(tbl[i].exp_busy));
      if (tbl[i].exp_in_valid)
        chk({nm, ".op1"}, div_operands_o[1], opval(int'(tbl[i].exp_g), 1));
      else
        chk({nm, ".op_zero"}, div_operands_o[1], 64'h0);
      cyc();
    end

    // Fill the tag FIFO, then show a pop does not bypass into a same-cycle grant
    do_reset();
    req_valid_i = 4'h1;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk_grant($sformatf("fill%0d", i), 4'h1, 0);
      cyc();
    end
    settle();
    chk("full.ready", 64'(req_ready_o), 64'h0);
    chk("full.in_valid", 64'(div_in_valid_o), 64'h0);
    chk("full.busy", 64'(busy_o), 64'h1);
    cyc();
    div_out_valid_i = 1'b1;
    settle();
    chk("popfull.resp_valid", 64'(resp_valid_o), 64'h1);
    chk("popfull.out_ready", 64'(div_out_ready_o), 64'h1);
    chk("popfull.no_bypass", 64'(req_ready_o), 64'h0);
    cyc();
    div_out_valid_i = 1'b0;
    settle();
    chk_grant("afterpop", 4'h1, 0);
    cyc();

    // Results routed back in issue order to requesters 2, 0, 3
    do_reset();
    req_valid_i = 4'h4; settle(); chk_grant("iss2", 4'h4, 2); cyc();
    req_valid_i = 4'h1; settle(); chk_grant("iss0", 4'h1, 0); cyc();
    req_valid_i = 4'h8; settle(); chk_grant("iss3", 4'h8, 3); cyc();
    req_valid_i = 4'h0;
    div_out_valid_i = 1'b1; div_result_i = {64'h0, F5}; div_status_i = 5'h00;
    settle();
    chk("ret5.valid", 64'(resp_valid_o), 64'h4);
    chk("ret5.result", resp_result_o[0], F5);
    chk("ret5.out_ready", 64'(div_out_ready_o), 64'h1);
    cyc();
    div_result_i = {64'h0, F7}; resp_ready_i = 4'hE;
    settle();
    chk("ret7stall.valid", 64'(resp_valid_o), 64'h1);
    chk("ret7stall.out_ready", 64'(div_out_ready_o), 64'h0);
    cyc();
    resp_ready_i = 4'hF;
    settle();
    chk("ret7.valid", 64'(resp_valid_o), 64'h1);
    chk("ret7.result", resp_result_o[0], F7);
    chk("ret7.out_ready", 64'(div_out_ready_o), 64'h1);
    cyc();
    div_result_i = {64'h0, F9}; div_status_i = 5'h01;
    settle();
    chk("ret9.valid", 64'(resp_valid_o), 64'h8);
    chk("ret9.result", resp_result_o[0], F9);
    chk("ret9.status", 64'(resp_status_o), 64'h1);
    cyc();
    div_out_valid_i = 1'b0;
    settle();
    chk("drained.busy", 64'(busy_o), 64'h0);
    cyc();

    // Flush with three in flight keeps rr_ptr
    do_reset();
    req_valid_i = 4'h7;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_grant($sformatf("fl_iss%0d", i), 4'(1 << i), i);
      cyc();
    end
    flush_i = 1'b1; div_out_valid_i = 1'b1;
    settle();
    chk("flush.div_flush", 64'(div_flush_o), 64'h1);
    chk("flush.ready", 64'(req_ready_o), 64'h0);
    chk("flush.in_valid", 64'(div_in_valid_o), 64'h0);
    chk("flush.resp_valid", 64'(resp_valid_o), 64'h0);
    cyc();
    flush_i = 1'b0; div_out_valid_i = 1'b0; req_valid_i = 4'h0;
    settle();
    chk("postflush.busy", 64'(busy_o), 64'h0);
    chk("postflush.div_flush", 64'(div_flush_o), 64'h0);
    cyc();
    req_valid_i = 4'hF;
    settle();
    chk_grant("postflush.rr", 4'h8, 3);
    cyc();

    // Reset while holding a stalled grant with two in flight
    do_reset();
    req_valid_i = 4'h3;
    settle(); chk_grant("r6_iss0", 4'h1, 0); cyc();
    settle(); chk_grant("r6_iss1", 4'h2, 1); cyc();
    req_valid_i = 4'h4; div_in_ready_i = 1'b0;
    settle();
    chk("r6_hold.ready", 64'(req_ready_o), 64'h0);
    chk("r6_hold.in_valid", 64'(div_in_valid_o), 64'h1);
    cyc();
    rst_i = 1'b1;
    settle();
    chk("r6_rst.in_valid", 64'(div_in_valid_o), 64'h0);
    chk("r6_rst.busy", 64'(busy_o), 64'h0);
    chk("r6_rst.op", div_operands_o[0], 64'h0);
    cyc();
    rst_i = 1'b0; req_valid_i = 4'h0; div_in_ready_i = 1'b1;
    settle();
    chk("r6_after.busy", 64'(busy_o), 64'h0);
    chk("r6_after.in_valid", 64'(div_in_valid_o), 64'h0);
    chk("r6_after.ready", 64'(req_ready_o), 64'h0);
    cyc();
    req_valid_i = 4'hF;
    settle();
    chk_grant("r6_after.rr", 4'h1, 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
